// File: rtl/e15_prog_loader.sv
// E15 program loader: packs a nibble stream into 12-bit instructions, writes them to instruction memory, and holds the CPU until the load is complete.
// Optional build macro E15_LOADER_OPCHECK_EN: reject illegal opcodes and lock into ERR.
module e15_prog_loader #(
  parameter int WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [3:0]  in_nib,
  output logic        in_ready,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [11:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, LOAD, LAST, DONE, ERR} state_t;

  localparam logic [4:0] LAST_WORD = 5'(WORDS - 1);

  state_t     state;
  logic [1:0] nibIdx;
  logic [4:0] wordCnt;
  logic [3:0] opNib;
  logic [3:0] sdNib;
  logic       accept;

  assign accept = in_valid && in_ready;

`ifdef E15_LOADER_OPCHECK_EN
  // Legal opcodes: 0000, 0010, 0011 and the whole 1xxx range.
  function automatic logic legalOp(input logic [3:0] op);
    return op[3] || (op == 4'h0) || (op == 4'h2) || (op == 4'h3);
  endfunction
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      nibIdx   <= '0;
      wordCnt  <= '0;
      opNib    <= '0;
      sdNib    <= '0;
`ifdef E15_LOADER_OPCHECK_EN
      err      <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          nibIdx  <= '0;
          wordCnt <= '0;
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            case (nibIdx)
              2'd0: begin
                opNib  <= in_nib;
                nibIdx <= 2'd1;
`ifdef E15_LOADER_OPCHECK_EN
                if (!legalOp(in_nib)) begin
                  state    <= ERR;
                  in_ready <= 1'b0;
                  err      <= 1'b1;
                  nibIdx   <= '0;
                end
`endif
              end
              2'd1: begin
                sdNib  <= in_nib;
                nibIdx <= 2'd2;
              end
              default: begin
                nibIdx  <= '0;
                wr_en   <= 1'b1;
                wr_data <= {opNib, sdNib, in_nib};
                wr_addr <= wordCnt[3:0];
                wordCnt <= wordCnt + 5'd1;
                // Stop accepting as soon as the final nibble is in; LAST covers its write cycle.
                if (wordCnt == LAST_WORD) begin
                  state    <= LAST;
                  in_ready <= 1'b0;
                end
              end
            endcase
          end
        end
        LAST: begin
          state    <= DONE;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
        DONE: begin
          if (start) begin
            state    <= LOAD;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
            in_ready <= 1'b1;
            nibIdx   <= '0;
            wordCnt  <= '0;
          end
        end
        ERR: begin
          in_ready <= 1'b0;
          cpu_hold <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e15_prog_loader.sv
// Directed bench for e15_prog_loader: full load, backpressure, mid-load reset, reload and illegal-opcode handling.
module tb_e15_prog_loader;
  localparam int WORDS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [3:0]  in_nib;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [11:0] prog [16] = '{12'h905, 12'hB13, 12'h2A7, 12'h3C4, 12'h8F0, 12'hD21, 12'h0E9, 12'hA5B,
                             12'hF66, 12'hC3D, 12'h2B8, 12'hE07, 12'h9D1, 12'h3F2, 12'hB4C, 12'h8A6};

  logic [3:0]  wa [$];
  logic [11:0] wd [$];

  always #5 clk = ~clk;

  e15_prog_loader #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_nib(in_nib),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled just after the edge so negedge checks see a settled log.
  always @(posedge clk) begin
    #1;
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      $display("[TB] t=%0t write addr=%0d data=%03h", $time, wr_addr, wr_data);
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sendNib(input logic [3:0] nib, input bit gaps);
    int guard;
    int g;
    if (gaps) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        in_valid = 1'b0;
        in_nib   = 4'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_nib   = nib;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkEq("in_ready_timeout", {31'd0, in_ready}, 1);
    @(negedge clk);
  endtask

  task automatic sendWord(input logic [11:0] w, input bit gaps);
    sendNib(w[11:8], gaps);
    sendNib(w[7:4], gaps);
    sendNib(w[3:0], gaps);
  endtask

  task automatic doStart(output int edgeIdx);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    edgeIdx = cyc;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitDone(output int edgeIdx);
    int guard;
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!done) checkEq("done_timeout", {31'd0, done}, 1);
    edgeIdx = cyc;
  endtask

  task automatic checkResetVals(input string pfx);
    checkEq({pfx, "_in_ready"}, {31'd0, in_ready}, 0);
    checkEq({pfx, "_wr_en"},    {31'd0, wr_en}, 0);
    checkEq({pfx, "_wr_addr"},  {28'd0, wr_addr}, 0);
    checkEq({pfx, "_wr_data"},  {20'd0, wr_data}, 0);
    checkEq({pfx, "_cpu_hold"}, {31'd0, cpu_hold}, 1);
    checkEq({pfx, "_done"},     {31'd0, done}, 0);
    checkEq({pfx, "_err"},      {31'd0, err}, 0);
  endtask

  task automatic checkWrites(input string tag, input int n);
    checkEq({tag, "_count"}, wa.size(), n);
    for (int i = 0; i < n && i < wa.size(); i++) begin
      checkEq($sformatf("%s_addr%0d", tag, i), {28'd0, wa[i]}, i);
      checkEq($sformatf("%s_data%0d", tag, i), {20'd0, wd[i]}, {20'd0, prog[i]});
    end
  endtask

  initial begin
    int s0;
    int d;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_nib = 4'h0;
    @(negedge clk);
    @(negedge clk);
    checkResetVals("reset");
    rst = 1'b0;
    @(negedge clk);
    checkEq("idle_in_ready", {31'd0, in_ready}, 0);

    // Full load at full throughput; done is expected on the 50th edge counting the start-sampling edge.
    wa.delete(); wd.delete();
    doStart(s0);
    checkEq("start_in_ready", {31'd0, in_ready}, 1);
    for (int w = 0; w < WORDS; w++) sendWord(prog[w], 1'b0);
    in_valid = 1'b0;
    waitDone(d);
    checkEq("load_latency", d - s0 + 1, 50);
    checkEq("full_done", {31'd0, done}, 1);
    checkEq("full_cpu_hold", {31'd0, cpu_hold}, 0);
    checkWrites("full", 16);

    // in_valid must be ignored while in DONE.
    wa.delete(); wd.delete();
    in_valid = 1'b1; in_nib = 4'h9;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checkEq("done_no_write", wa.size(), 0);
    checkEq("done_in_ready", {31'd0, in_ready}, 0);

    // Reload from DONE, then reset after the 2nd nibble of word 3.
    doStart(s0);
    checkEq("reload_cpu_hold", {31'd0, cpu_hold}, 1);
    checkEq("reload_done", {31'd0, done}, 0);
    checkEq("reload_in_ready", {31'd0, in_ready}, 1);
    for (int w = 0; w < 3; w++) sendWord(prog[w], 1'b0);
    sendNib(prog[3][11:8], 1'b0);
    sendNib(prog[3][7:4], 1'b0);
    in_valid = 1'b0;
    doReset();
    checkResetVals("midrst");
    @(negedge clk);
    checkWrites("reload", 3);

    // Backpressure: random valid gaps must not change the written image.
    wa.delete(); wd.delete();
    doStart(s0);
    for (int w = 0; w < WORDS; w++) sendWord(prog[w], 1'b1);
    in_valid = 1'b0;
    waitDone(d);
    checkEq("gaps_done", {31'd0, done}, 1);
    checkWrites("gaps", 16);

    // Illegal opcode 0100 at word 2.
    doReset();
    wa.delete(); wd.delete();
    doStart(s0);
    sendWord(prog[0], 1'b0);
    sendWord(prog[1], 1'b0);
`ifdef E15_LOADER_OPCHECK_EN
    sendNib(4'h4, 1'b0);
    in_valid = 1'b0;
    checkEq("ill_err", {31'd0, err}, 1);
    checkEq("ill_in_ready", {31'd0, in_ready}, 0);
    checkEq("ill_cpu_hold", {31'd0, cpu_hold}, 1);
    repeat (3) @(negedge clk);
    checkWrites("ill", 2);
    doStart(s0);
    @(negedge clk);
    checkEq("ill_start_ignored", {31'd0, in_ready}, 0);
    checkEq("ill_err_held", {31'd0, err}, 1);
    checkEq("ill_hold_held", {31'd0, cpu_hold}, 1);
    doReset();
    checkEq("ill_err_cleared", {31'd0, err}, 0);
`else
    sendWord(12'h4A5, 1'b0);
    for (int w = 3; w < WORDS; w++) sendWord(prog[w], 1'b0);
    in_valid = 1'b0;
    waitDone(d);
    checkEq("op4_count", wa.size(), 16);
    checkEq("op4_addr2", {28'd0, wa[2]}, 2);
    checkEq("op4_data2", {20'd0, wd[2]}, 32'h4A5);
    checkEq("op4_err", {31'd0, err}, 0);
    checkEq("op4_done", {31'd0, done}, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
